// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encodings and 8N1 frame constants.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read and registered
// full/empty/level; overflow flags a push attempted while full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;
  logic [AW:0]      level_next;

  // full is the pre-edge value, so a push at full is refused even if a pop
  // frees a slot on the same edge.
  assign push     = wr && !full;
  assign pop      = rd && !empty;
  assign overflow = wr && full;
  assign rdata    = mem[rptr];

  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LEVEL_ONE;
    end else if (pop && !push) begin
      level_next = level - LEVEL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      level <= level_next;
      full  <= (level_next == FULL_LEVEL);
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a FIFO absorbs byte bursts and a four-state
// serializer drains it onto a registered, glitch-free tx line.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int BAUDRATE = 104,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr,
  input  logic [7:0]             data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   busy,
  output logic                   tx
);

  if (BAUDRATE < 2) begin : g_bad_baud
    $error("uart_tx_fifo: BAUDRATE must be at least 2");
  end
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two in 2..256");
  end
  if (FRAME_BITS != DATA_BITS + 2) begin : g_bad_frame
    $error("uart_tx_fifo: frame must be start + data + one stop bit");
  end

  localparam int CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t     state;
  tx_state_t     state_next;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] cnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic [7:0]    fifo_data;
  logic          pop;
  logic          tick;
  logic          tx_next;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr       (wr),
    .wdata    (data),
    .rd       (pop),
    .rdata    (fifo_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  assign tick = (baud_cnt == LAST_CNT);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= cnt_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

  // Every state except IDLE spends BAUDRATE cycles per bit; IDLE lasts a
  // single cycle between back-to-back frames, which is why frames start
  // 10*BAUDRATE+1 cycles apart.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        cnt_next = tick ? '0 : baud_cnt + CNT_ONE;
        if (tick) begin
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        cnt_next = tick ? '0 : baud_cnt + CNT_ONE;
        if (tick) begin
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        cnt_next = tick ? '0 : baud_cnt + CNT_ONE;
        if (tick) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is registered from the current state, so tx trails the
  // state register by one cycle and never glitches within a bit.
  always_comb begin
    tx_next = 1'b1;
    unique case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter: bytes are pushed into an internal FIFO from the fabric side, and the block serializes them onto the tx line at a fixed clock-per-bit rate. It is the drain end of host-bound traffic, feeding a USB-UART bridge. It lets producers such as status/report generators burst several bytes without waiting a full frame per byte. Runs on the SB_HFOSC-derived system clock.

Parameters:
BAUDRATE, 104, clock cycles per bit; values come from the baudgen.vh macros (`B115200 etc.); must be >= 2.
DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
wr  input  1  push strobe; data accepted on a rising clk edge when wr=1 and full=0
data  input  8  byte to push, sampled with wr
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  $clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  one-cycle pulse when wr=1 while full=1 (byte dropped)
busy  output  1  serializer is mid-frame (state != IDLE)
tx  output  1  serial line, idle high

Behaviour:
- Reset (rstn=0, asynchronous): tx=1, busy=0, full=0, empty=1, level=0, overflow=0; FIFO pointers cleared; serializer to IDLE. Reset mid-frame truncates the frame; tx is high immediately; buffered bytes are discarded.
- FIFO: synchronous write, first-word-fall-through read. full, empty and level are registered and reflect the state after the edge.
- Push while full: the byte is dropped, overflow=1 for that cycle only, and FIFO contents are unchanged.
- Push and pop in the same edge: level is unchanged and both the write and the read complete. full is evaluated before the pop, so a push at full is still rejected even when a pop occurs in the same edge.
- Push at empty cannot pop in the same edge. The pop happens on the next edge.
- Serializer FSM states are IDLE, START, DATA and STOP.
  - IDLE: tx=1. If empty=0, pop the head byte into the shift register, clear the baud counter, and go to START.
  - START: tx=0 for BAUDRATE cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for BAUDRATE cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for BAUDRATE cycles. At the end of STOP, go to IDLE.
  - Baud counter runs 0..BAUDRATE-1 and wraps; the state advances on terminal count.
- Latency: a byte pushed into an empty FIFO at edge N, with the serializer IDLE, is popped at edge N+1. tx falls after edge N+2 (IDLE→START).
- Frame length is exactly 10*BAUDRATE cycles.
- Back-to-back frames:
  - The block returns to IDLE for exactly one cycle (tx=1) and then starts the next frame.
  - So inter-frame spacing is 10*BAUDRATE+1 cycles, start edge to start edge.
  - The stop bit is never shortened.
- The data input is ignored when wr=0. tx never glitches inside a bit period, because it is driven from a register.

Decomposition:
- Shared header uart_defs.vh, alongside baudgen.vh, holds:
  - the serializer state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3);
  - the frame constants DATA_BITS=8 and FRAME_BITS=10.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH). It holds the storage, read/write pointers, full/empty/level and the overflow pulse.
- The serializer FSM and baud counter live in uart_tx_fifo.

Test Plan:
1. Reset, then push 0x55 once (bench uses BAUDRATE=4):
   - tx falls 2 cycles after the push edge.
   - Line reads 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles wide.
   - busy=1 for exactly 40 cycles; empty returns to 1 one cycle after the push edge.
2. Push 0x41, 0x42, 0x43 on consecutive cycles:
   - level peaks at 2 (one byte is popped the edge after the first push);
   - three frames are decoded in order 0x41, 0x42, 0x43;
   - start-to-start spacing is 41 cycles; tx stays high after the third stop bit.
3. With tx stalled mid-frame, push 17 bytes into DEPTH=16:
   - the 16th accepted push sets full=1 (one byte is already in the shifter);
   - the next push pulses overflow for 1 cycle and is dropped;
   - all 16 buffered bytes plus the in-flight byte transmit in order.
4. At full, assert wr on the same edge as the serializer's pop:
   - the write is rejected (overflow=1);
   - level drops to DEPTH-1 and full=0 next cycle.
5. Assert rstn=0 during DATA bit 3 of 0xA5 with 4 bytes queued:
   - tx=1 and busy=0 asynchronously;
   - level=0 and empty=1;
   - after release, no frame is emitted until a new push.
6. Push 0x00 and 0xFF:
   - 0x00 gives a 36-cycle low then a stop bit;
   - 0xFF gives a 4-cycle low start bit then a high line;
   - stop bits are verified as exactly 4 cycles.
